axi_lite_read_master: RTL and testbench

AXI-lite read-channel initiator that turns single-beat read requests from a core-side valid/ready port into AR/R transactions toward an AXI-lite read slave, such as the team's SRAM model. It sits between the IFU/LSU fetch logic and the memory-side AXI-lite bus. It issues one outstanding transaction at a time and returns the read data, plus an error flag, on a response port that tolerates backpressure.

---
 rtl/axi_lite_read_master.sv | 145 ++++++++++++++
 tb/tb_axi_lite_read_master.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_read_master.sv
// Single-outstanding AXI-lite read initiator: core request/response port to AR/R channels.
// Optional watchdog on AR/R, built only when AXI_RD_TIMEOUT_EN is defined.
module axi_lite_read_master #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              m_axi_arvalid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  input  logic              m_axi_arready,
  input  logic              m_axi_rvalid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  output logic              m_axi_rready
);

  // Valid/ready: a transfer happens on a rising clk edge where valid and ready are both
  // high; a raised valid keeps its payload stable until that edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              timeout_hit;
  logic              err_out;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (m_axi_arready) begin
          state_d = ST_R;
        end else if (timeout_hit) begin
          data_d  = '0;
          state_d = ST_RESP;
        end
      end
      ST_R: begin
        if (m_axi_rvalid) begin
          data_d  = m_axi_rdata;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          data_d  = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef AXI_RD_TIMEOUT_EN
  localparam int CNT_RAW_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W     = (CNT_RAW_W < 8) ? 8 : CNT_RAW_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic             to_fire;

  // cnt_q counts completed AR/R cycles, so the watchdog fires at the end of the
  // TIMEOUT_CYCLES-th cycle spent waiting.
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign to_fire     = timeout_hit &&
                       (((state_q == ST_AR) && !m_axi_arready) ||
                        ((state_q == ST_R)  && !m_axi_rvalid));

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      cnt_d = '0;
    end else if ((state_q == ST_AR) || (state_q == ST_R)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (to_fire) begin
        err_q <= 1'b1;
      end else if ((state_q == ST_R) && m_axi_rvalid) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err_out = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign err_out            = 1'b0;
`endif

  // req_ready is the only output that looks at rst_n directly.
  assign req_ready     = rst_n && (state_q == ST_IDLE);
  assign m_axi_arvalid = (state_q == ST_AR);
  assign m_axi_araddr  = (state_q == ST_AR) ? addr_q : '0;
  assign m_axi_rready  = (state_q == ST_R);
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_data     = (state_q == ST_RESP) ? data_q : '0;
  assign resp_err      = (state_q == ST_RESP) ? err_out : 1'b0;

endmodule

// File: tb/tb_axi_lite_read_master.sv
// Testbench for axi_lite_read_master: behavioural AXI-lite slave, response scoreboard,
// one task per scenario. The watchdog scenario runs when AXI_RD_TIMEOUT_EN is defined.
module tb_axi_lite_read_master;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int TO_CYC = 16;
  localparam int EXP_W  = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              m_axi_arvalid;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arready = 1'b0;
  logic              m_axi_rvalid = 1'b0;
  logic [DATA_W-1:0] m_axi_rdata = '0;
  logic              m_axi_rready;

  axi_lite_read_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arready(m_axi_arready), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rready(m_axi_rready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int resp_hs_cyc = -1;
  int ar_hs_cnt = 0;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W-1:0] a);
    case (a)
      64'h0000_0000_8000_0000: return 32'hDEAD_BEEF;
      64'h0000_0000_0000_2000: return 32'h1234_5678;
      default:                 return a[31:0] ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  // ---------------- AXI-lite slave model ----------------
  // Acts 1 time unit after each rising edge: arready after ar_stall AR cycles,
  // rvalid after r_lat R cycles; sl_ar_en=0 never accepts AR.
  int               ar_stall = 0;
  int               r_lat    = 0;
  bit               sl_ar_en = 1'b1;
  int               sl_phase = 0;
  int               sl_cnt   = 0;
  logic [ADDR_W-1:0] sl_addr = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rdata   = '0;
      sl_phase      = 0;
      sl_cnt        = 0;
    end else begin
      if (m_axi_arready) begin
        m_axi_arready = 1'b0;
        sl_phase      = 1;
        sl_cnt        = 0;
      end else if (m_axi_rvalid) begin
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        sl_phase     = 0;
        sl_cnt       = 0;
      end
      if (sl_phase == 0 && m_axi_arvalid && sl_ar_en) begin
        if (sl_cnt >= ar_stall) begin
          m_axi_arready = 1'b1;
          sl_addr       = m_axi_araddr;
        end else begin
          sl_cnt++;
        end
      end else if (sl_phase == 1 && m_axi_rready) begin
        if (sl_cnt >= r_lat) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = model_data(sl_addr);
        end else begin
          sl_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] exp;
    if (rst_n && m_axi_arvalid && m_axi_arready) ar_hs_cnt++;
    if (rst_n && resp_valid && resp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=%h err=%b, required no response", resp_data, resp_err);
      end else begin
        exp = exp_q.pop_front();
        if ({resp_err, resp_data} !== exp) begin
          errors++;
          $display("FAIL sb_resp: got err=%b data=%h, required err=%b data=%h",
                   resp_err, resp_data, exp[DATA_W], exp[DATA_W-1:0]);
        end
      end
      resp_cnt++;
      resp_hs_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_point();
    @(posedge clk);
    #3;
  endtask

  task automatic send_req(input logic [ADDR_W-1:0] a, input logic [EXP_W-1:0] e, output int hs_cyc);
    drive_point();
    req_valid = 1'b1;
    req_addr  = a;
    exp_q.push_back(e);
    hs_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin
        hs_cyc = cyc;
        break;
      end
    end
    if (hs_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL req_accept: req_ready=%b after 60 cycles, required 1", req_ready);
    end
    drive_point();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 80; i++) begin
      if (resp_cnt >= target) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL resp_wait: resp_cnt=%0d, required %0d", resp_cnt, target);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, m_axi_arvalid, m_axi_rready, resp_valid, resp_err} !== 5'b0 ||
        m_axi_araddr !== '0 || resp_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b arv=%b rr=%b rv=%b err=%b araddr=%h data=%h, required all 0",
               req_ready, m_axi_arvalid, m_axi_rready, resp_valid, resp_err, m_axi_araddr, resp_data);
    end
    drive_point();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || m_axi_arvalid !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b arvalid=%b resp_valid=%b, required 1 0 0",
               req_ready, m_axi_arvalid, resp_valid);
    end
  endtask

  task automatic test_basic();
    int hs;
    int lat;
    ar_stall = 0;
    r_lat = 0;
    resp_ready = 1'b1;
    send_req(64'h8000_0000, {1'b0, 32'hDEAD_BEEF}, hs);
    @(negedge clk);
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL basic_ar: arvalid=%b araddr=%h, required 1 0000000080000000", m_axi_arvalid, m_axi_araddr);
    end
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin
        lat = cyc - hs;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, required 3", lat);
    end
    checks++;
    if (resp_data !== 32'hDEAD_BEEF || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_resp: data=%h err=%b, required deadbeef 0", resp_data, resp_err);
    end
    wait_resp(resp_cnt + 1);
  endtask

  task automatic test_ar_stall();
    int hs;
    int low_cyc;
    int bad;
    int hs_before;
    int target;
    hs_before = ar_hs_cnt;
    target = resp_cnt + 1;
    ar_stall = 5;
    send_req(64'h3000, {1'b0, model_data(64'h3000)}, hs);
    low_cyc = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h3000) bad++;
      if (m_axi_arready) break;
      low_cyc++;
    end
    checks++;
    if (bad != 0 || low_cyc != 5) begin
      errors++;
      $display("FAIL ar_stall_hold: unstable=%0d low_cycles=%0d, required 0 and 5", bad, low_cyc);
    end
    ar_stall = 0;
    wait_resp(target);
    checks++;
    if (ar_hs_cnt - hs_before != 1) begin
      errors++;
      $display("FAIL ar_stall_count: handshakes=%0d, required 1", ar_hs_cnt - hs_before);
    end
  endtask

  task automatic test_resp_backpressure();
    int hs;
    int bad;
    int hs_before;
    int target;
    hs_before = ar_hs_cnt;
    target = resp_cnt + 1;
    resp_ready = 1'b0;
    send_req(64'h2000, {1'b0, 32'h1234_5678}, hs);
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) break;
      @(negedge clk);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      drive_point();
      req_valid = 1'b1;
      req_addr  = 64'h4000;
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== 32'h1234_5678 || resp_err !== 1'b0 || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d of 4 cycles wrong, last rv=%b data=%h rdy=%b, required 1 12345678 0",
               bad, resp_valid, resp_data, req_ready);
    end
    drive_point();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    wait_resp(target);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_axi_arvalid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || ar_hs_cnt - hs_before != 1) begin
      errors++;
      $display("FAIL bp_ignored_req: arvalid_cycles=%0d handshakes=%0d, required 0 and 1", bad, ar_hs_cnt - hs_before);
    end
  endtask

  task automatic test_back_to_back();
    int hs1;
    int hs2;
    int first_resp;
    int target;
    target = resp_cnt + 2;
    resp_ready = 1'b1;
    send_req(64'h1000, {1'b0, model_data(64'h1000)}, hs1);
    send_req(64'h1004, {1'b0, model_data(64'h1004)}, hs2);
    first_resp = resp_hs_cyc;
    checks++;
    if (hs2 - hs1 != 4) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, required 4", hs2 - hs1);
    end
    @(negedge clk);
    checks++;
    if (m_axi_arvalid !== 1'b1 || cyc != first_resp + 2 || m_axi_araddr !== 64'h1004) begin
      errors++;
      $display("FAIL b2b_arvalid: arvalid=%b at resp_hs+%0d addr=%h, required 1 at +2 addr 1004",
               m_axi_arvalid, cyc - first_resp, m_axi_araddr);
    end
    wait_resp(target);
  endtask

  task automatic test_reset_in_r();
    int hs;
    int cnt_before;
    bit seen_r;
    r_lat = 10;
    send_req(64'h5000, {1'b0, model_data(64'h5000)}, hs);
    seen_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_axi_rready) begin
        seen_r = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen_r) begin
      errors++;
      $display("FAIL rst_reach_r: rready=%b, required 1", m_axi_rready);
    end
    cnt_before = resp_cnt;
    drive_point();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_gate: req_ready=%b resp_valid=%b, required 0 0", req_ready, resp_valid);
    end
    @(negedge clk);
    checks++;
    if ({req_ready, m_axi_arvalid, m_axi_rready, resp_valid, resp_err} !== 5'b0 ||
        m_axi_araddr !== '0 || resp_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: rdy=%b arv=%b rr=%b rv=%b err=%b, required all 0",
               req_ready, m_axi_arvalid, m_axi_rready, resp_valid, resp_err);
    end
    drive_point();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    r_lat = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (resp_cnt != cnt_before) begin
      errors++;
      $display("FAIL rst_no_resp: responses=%0d, required %0d", resp_cnt, cnt_before);
    end
    send_req(64'h6000, {1'b0, model_data(64'h6000)}, hs);
    wait_resp(cnt_before + 1);
  endtask

  task automatic test_random();
    int hs;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 8; i++) begin
      ar_stall = $urandom_range(0, 3);
      r_lat    = $urandom_range(0, 3);
      a = ADDR_W'({$urandom_range(0, 1023), 2'b00});
      send_req(a, {1'b0, model_data(a)}, hs);
      wait_resp(resp_cnt + 1);
    end
    ar_stall = 0;
    r_lat = 0;
  endtask

`ifdef AXI_RD_TIMEOUT_EN
  task automatic test_timeout();
    int hs;
    int ar_cyc;
    int bad;
    sl_ar_en = 1'b0;
    resp_ready = 1'b0;
    send_req(64'h7000, {1'b1, {DATA_W{1'b0}}}, hs);
    ar_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) break;
      if (m_axi_arvalid) ar_cyc++;
    end
    checks++;
    if (ar_cyc != TO_CYC || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_cycles: arvalid for %0d cycles resp_valid=%b, required %0d and 1",
               ar_cyc, resp_valid, TO_CYC);
    end
    checks++;
    if (resp_err !== 1'b1 || resp_data !== '0 || m_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resp: err=%b data=%h arvalid=%b, required 1 00000000 0",
               resp_err, resp_data, m_axi_arvalid);
    end
    drive_point();
    resp_ready = 1'b1;
    wait_resp(resp_cnt + 1);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_axi_arvalid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_arvalid_low: arvalid high %0d cycles, required 0", bad);
    end
    drive_point();
    rst_n = 1'b0;
    drive_point();
    rst_n = 1'b1;
    sl_ar_en = 1'b1;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_ar_stall();
    test_resp_backpressure();
    test_back_to_back();
    test_reset_in_r();
    test_random();
`ifdef AXI_RD_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses missing, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
